// File: rtl/mem_arbiter.sv
// mem_arbiter: merges the core's ibus and dbus onto a single memory request
// bus with at most one outstanding transaction and round-robin arbitration.
// Optional performance counters are built when MEM_ARB_PERF_EN is defined;
// otherwise perf_icnt/perf_dcnt/perf_wait are tied to zero.
module mem_arbiter #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ireq_valid,
  input  logic [ADDR_W-1:0] ireq_addr,
  output logic              iresp_addr_ok,
  output logic              iresp_data_ok,
  output logic [31:0]       iresp_data,
  input  logic              dreq_valid,
  input  logic [ADDR_W-1:0] dreq_addr,
  input  logic [2:0]        dreq_size,
  input  logic [7:0]        dreq_strobe,
  input  logic [DATA_W-1:0] dreq_data,
  output logic              dresp_addr_ok,
  output logic              dresp_data_ok,
  output logic [DATA_W-1:0] dresp_data,
  output logic              mreq_valid,
  input  logic              mreq_ready,
  output logic              mreq_write,
  output logic [ADDR_W-1:0] mreq_addr,
  output logic [2:0]        mreq_size,
  output logic [7:0]        mreq_strobe,
  output logic [DATA_W-1:0] mreq_data,
  input  logic              mresp_valid,
  input  logic [DATA_W-1:0] mresp_data,
  output logic [31:0]       perf_icnt,
  output logic [31:0]       perf_dcnt,
  output logic [31:0]       perf_wait
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    REQ_I  = 3'd1,
    REQ_D  = 3'd2,
    WAIT_I = 3'd3,
    WAIT_D = 3'd4
  } state_t;

  state_t state;
  logic   rr_d;      // 1: dbus wins the next contested grant
  logic   grant_d;
  logic   grant_i;

  // Contested grants follow rr_d; an uncontested requester always wins.
  always_comb begin
    grant_d = dreq_valid && (!ireq_valid || rr_d);
    grant_i = ireq_valid && !grant_d;
  end

  // Arbitration FSM; latched request and mreq_valid are registered outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= IDLE;
      rr_d        <= 1'b1;
      mreq_valid  <= 1'b0;
      mreq_write  <= 1'b0;
      mreq_addr   <= '0;
      mreq_size   <= '0;
      mreq_strobe <= '0;
      mreq_data   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (ireq_valid && dreq_valid) rr_d <= ~rr_d;
          if (grant_d) begin
            state       <= REQ_D;
            mreq_valid  <= 1'b1;
            mreq_write  <= |dreq_strobe;
            mreq_addr   <= dreq_addr;
            mreq_size   <= dreq_size;
            mreq_strobe <= dreq_strobe;
            mreq_data   <= dreq_data;
          end else if (grant_i) begin
            state       <= REQ_I;
            mreq_valid  <= 1'b1;
            mreq_write  <= 1'b0;
            mreq_addr   <= ireq_addr;
            mreq_size   <= 3'b010;
            mreq_strobe <= '0;
            mreq_data   <= '0;
          end
        end
        REQ_I: if (mreq_ready) begin
          state      <= WAIT_I;
          mreq_valid <= 1'b0;
        end
        REQ_D: if (mreq_ready) begin
          state      <= WAIT_D;
          mreq_valid <= 1'b0;
        end
        WAIT_I: if (mresp_valid) state <= IDLE;
        WAIT_D: if (mresp_valid) state <= IDLE;
        default: begin
          state      <= IDLE;
          mreq_valid <= 1'b0;
        end
      endcase
    end
  end

  // Handshake pulses and response routing; data buses read zero when idle.
  always_comb begin
    iresp_addr_ok = (state == REQ_I) && mreq_ready;
    dresp_addr_ok = (state == REQ_D) && mreq_ready;
    iresp_data_ok = (state == WAIT_I) && mresp_valid;
    dresp_data_ok = (state == WAIT_D) && mresp_valid;
    iresp_data    = '0;
    dresp_data    = '0;
    if (iresp_data_ok) iresp_data = mreq_addr[2] ? mresp_data[63:32] : mresp_data[31:0];
    if (dresp_data_ok) dresp_data = mresp_data;
  end

`ifdef MEM_ARB_PERF_EN
  // Completion counts per bus and cycles spent with a transaction in flight.
  always_ff @(posedge clk) begin
    if (!reset) begin
      perf_icnt <= '0;
      perf_dcnt <= '0;
      perf_wait <= '0;
    end else begin
      if (iresp_data_ok) perf_icnt <= perf_icnt + 32'd1;
      if (dresp_data_ok) perf_dcnt <= perf_dcnt + 32'd1;
      if (state != IDLE) perf_wait <= perf_wait + 32'd1;
    end
  end
`else
  assign perf_icnt = '0;
  assign perf_dcnt = '0;
  assign perf_wait = '0;
`endif

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Sits directly downstream of the pipeline core.
- Merges the core's instruction bus (ibus) and data bus (dbus) onto one memory request bus, with at most one outstanding transaction.
- Latches the granted request, holds it stable until the memory side accepts it, then routes the response back to the requester as data_ok plus data.
- Uses round-robin arbitration. This matters because the core holds ireq valid permanently, so a fixed ibus priority would starve the dbus.

Parameters:
- ADDR_W, 64, address width of both upstream buses and the memory bus.
- DATA_W, 64, memory data width; fixed at 64 (the ibus extracts a 32-bit lane).

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-low reset (0 = reset), sampled on posedge clk.
- ireq_valid  in  1  instruction fetch request.
- ireq_addr  in  ADDR_W  fetch address, 4-byte aligned.
- iresp_addr_ok  out  1  fetch request accepted by memory.
- iresp_data_ok  out  1  fetch data valid (1-cycle pulse).
- iresp_data  out  32  instruction word.
- dreq_valid  in  1  data request.
- dreq_addr  in  ADDR_W  data address.
- dreq_size  in  3  log2 of access bytes (0–3).
- dreq_strobe  in  8  byte write enables; 0 = read.
- dreq_data  in  64  write data.
- dresp_addr_ok  out  1  data request accepted.
- dresp_data_ok  out  1  data response valid (1-cycle pulse).
- dresp_data  out  64  read data.
- mreq_valid  out  1  memory request valid.
- mreq_ready  in  1  memory accepts request this cycle.
- mreq_write  out  1  write request (= |strobe).
- mreq_addr  out  ADDR_W  request address.
- mreq_size  out  3  request size.
- mreq_strobe  out  8  byte enables.
- mreq_data  out  64  write data.
- mresp_valid  in  1  memory response valid (1 cycle).
- mresp_data  in  64  read data.
- perf_icnt, perf_dcnt, perf_wait  out  32 each  performance counters (see Optional Feature).

Behaviour:
- States: IDLE, REQ_I, REQ_D, WAIT_I, WAIT_D. State is one-hot or encoded, implementer's choice.
- Reset (reset==0 at posedge):
  - state to IDLE, rr_ptr to DBUS.
  - All request registers to 0.
  - All outputs 0 in the following cycle.
  - A pending mresp_valid is dropped. Reset applied mid-transaction abandons it silently.
- IDLE grant rule:
  - Only dreq_valid: grant D.
  - Only ireq_valid: grant I.
  - Both valid: grant rr_ptr, then set rr_ptr to the other requester.
  - Neither valid: stay in IDLE.
- On grant, capture the request into registers.
  - Grant I: addr = ireq_addr, size = 3'b010, strobe = 0, write = 0.
  - Grant D: capture all dreq fields.
  - Next state is REQ_I or REQ_D.
- REQ_x:
  - mreq_valid = 1, driven from the latched registers and stable until accepted.
  - When mreq_ready is high: pulse x_addr_ok for that cycle, move to WAIT_x.
- WAIT_x:
  - mreq_valid = 0.
  - When mresp_valid is high: pulse x_data_ok combinationally in the same cycle, move to IDLE.
  - iresp_data = latched addr[2] ? mresp_data[63:32] : mresp_data[31:0].
  - dresp_data = mresp_data, unshifted; the core performs lane extraction.
- Latency:
  - Grant to mreq_valid: 1 cycle.
  - mresp_valid to data_ok: 0 cycles.
  - One IDLE bubble always separates consecutive transactions.
- mresp_valid outside WAIT_x is ignored.
- An upstream valid that drops after grant does not cancel the transaction. It completes and the data_ok pulse is still issued.
- data_ok and addr_ok are never both asserted on ibus and dbus in the same cycle.
- iresp_data and dresp_data are 0 whenever their data_ok is low.

Optional Feature:
- Macro MEM_ARB_PERF_EN.
- When defined:
  - perf_icnt increments once per iresp_data_ok.
  - perf_dcnt increments once per dresp_data_ok.
  - perf_wait increments every cycle the state is REQ_x or WAIT_x.
  - All three are 32-bit, wrap at 2^32−1 back to 0, and clear on reset.
- When undefined: the three ports are tied to constant 0 and no counter flops exist.

Test Plan:
- Only ireq_valid, addr 0x8000_0004; mreq_ready=1 immediately; mresp_data=0xAAAA_BBBB_CCCC_DDDD two cycles later -> mreq_size=2, iresp_data_ok pulses with iresp_data=0xAAAA_BBBB.
- Both valid out of reset, mreq_ready=1, responses 1 cycle after acceptance -> order is D, I, D, I; each grant is separated by one IDLE cycle; neither requester is starved.
- dreq_valid with strobe=0x0F, addr 0x8000_1000, data 0x1234; mreq_ready held low for 5 cycles -> mreq_valid and all mreq fields stay stable for 5 cycles; dresp_addr_ok pulses only on the 6th cycle; mreq_write=1.
- reset=0 asserted while in WAIT_D, then mresp_valid arrives after release -> no dresp_data_ok; state is IDLE; the next request is served normally.
- mresp_valid pulsed while in IDLE or REQ_I -> ignored, no data_ok on either bus.
- With MEM_ARB_PERF_EN: 3 fetches and 2 loads, each with 2-cycle memory latency -> perf_icnt=3, perf_dcnt=2, perf_wait equals the summed REQ+WAIT cycles. Without the macro: all three perf ports read 0.
